// File: rtl/leaf_stream_buffer_bank_if.sv
// Stream bundle between an HLS kernel and leaf_stream_buffer_bank: write side, read side, flush and occupancy.
interface leaf_stream_buffer_bank_if #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned DEPTH_BITS   = 4
);
    logic [NUM_CH*PAYLOAD_BITS-1:0]   din_user;
    logic [NUM_CH-1:0]                din_vld;
    logic [NUM_CH-1:0]                din_ack;
    logic [NUM_CH*PAYLOAD_BITS-1:0]   dout_user;
    logic [NUM_CH-1:0]                dout_vld;
    logic [NUM_CH-1:0]                dout_ack;
    logic [NUM_CH-1:0]                flush;
    logic [NUM_CH*(DEPTH_BITS+1)-1:0] occupancy;

    modport master (
        output din_user, din_vld, dout_ack, flush,
        input  din_ack, dout_user, dout_vld, occupancy
    );

    modport slave (
        input  din_user, din_vld, dout_ack, flush,
        output din_ack, dout_user, dout_vld, occupancy
    );
endinterface

// File: rtl/leaf_stream_buffer_bank.sv
// Bank of NUM_CH independent elastic FIFOs with per-channel flush and occupancy.
// Optional per-channel stall/high-water statistics under LEAF_STREAM_BUF_STATS_EN.
module leaf_stream_buffer_bank #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned DEPTH_BITS   = 4
) (
    input  logic clk_user,
    input  logic reset,
`ifdef LEAF_STREAM_BUF_STATS_EN
    output logic [NUM_CH*16-1:0]             stall_cnt,
    output logic [NUM_CH*(DEPTH_BITS+1)-1:0] high_water,
`endif
    leaf_stream_buffer_bank_if.slave bus
);
    localparam int unsigned DEPTH = 32'd1 << DEPTH_BITS;
    localparam int unsigned CW    = DEPTH_BITS + 1;
    localparam int unsigned PW    = DEPTH_BITS;

    logic [PW-1:0]           wr_ptr_q [NUM_CH];
    logic [PW-1:0]           wr_ptr_d [NUM_CH];
    logic [PW-1:0]           rd_ptr_q [NUM_CH];
    logic [PW-1:0]           rd_ptr_d [NUM_CH];
    logic [CW-1:0]           count_q  [NUM_CH];
    logic [CW-1:0]           count_d  [NUM_CH];
    logic [PAYLOAD_BITS-1:0] mem_q    [NUM_CH][DEPTH];
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       push;
    logic [NUM_CH-1:0]       pop;
    logic [NUM_CH-1:0]       wr_en;

    // Per-channel pointer/count update; flush discards any same-cycle push or pop
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            full[c]     = (count_q[c] == CW'(DEPTH));
            empty[c]    = (count_q[c] == '0);
            push[c]     = bus.din_vld[c] & ~full[c];
            pop[c]      = bus.dout_ack[c] & ~empty[c];
            wr_en[c]    = push[c] & ~bus.flush[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (bus.flush[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end else begin
                if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
                if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
                count_d[c] = count_q[c] + CW'(push[c]) - CW'(pop[c]);
            end
        end
    end

    always_ff @(posedge clk_user) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!reset) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end else begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk_user) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= bus.din_user[c*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // Handshake and head data derive only from registered pointers/counts
    always_comb begin
        bus.din_ack   = ~full;
        bus.dout_vld  = ~empty;
        bus.dout_user = '0;
        bus.occupancy = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            bus.dout_user[c*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[c][rd_ptr_q[c]];
            bus.occupancy[c*CW +: CW]                     = count_q[c];
        end
    end

`ifdef LEAF_STREAM_BUF_STATS_EN
    localparam int unsigned SW = 16;

    logic [SW-1:0] stall_cnt_q  [NUM_CH];
    logic [SW-1:0] stall_cnt_d  [NUM_CH];
    logic [CW-1:0] high_water_q [NUM_CH];
    logic [CW-1:0] high_water_d [NUM_CH];

    // High-water tracks the next count so it moves in step with occupancy
    always_comb begin
        stall_cnt  = '0;
        high_water = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            stall_cnt_d[c]  = stall_cnt_q[c];
            high_water_d[c] = high_water_q[c];
            if (bus.flush[c]) begin
                stall_cnt_d[c]  = '0;
                high_water_d[c] = '0;
            end else begin
                if (bus.din_vld[c] && full[c] && (stall_cnt_q[c] != '1))
                    stall_cnt_d[c] = stall_cnt_q[c] + SW'(1);
                if (count_d[c] > high_water_q[c])
                    high_water_d[c] = count_d[c];
            end
            stall_cnt[c*SW +: SW]  = stall_cnt_q[c];
            high_water[c*CW +: CW] = high_water_q[c];
        end
    end

    always_ff @(posedge clk_user) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!reset) begin
                stall_cnt_q[c]  <= '0;
                high_water_q[c] <= '0;
            end else begin
                stall_cnt_q[c]  <= stall_cnt_d[c];
                high_water_q[c] <= high_water_d[c];
            end
        end
    end
`endif
endmodule

// File: tb/tb_leaf_stream_buffer_bank.sv
// Self-checking bench for leaf_stream_buffer_bank: vector table, directed corner sequences and
// randomized traffic against a queue-based reference; stats checks when LEAF_STREAM_BUF_STATS_EN is set.
module tb_leaf_stream_buffer_bank;
    localparam int unsigned NCH   = 2;
    localparam int unsigned PB    = 32;
    localparam int unsigned DB    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = DB + 1;

    typedef struct {
        logic           rst_n;
        logic [1:0]     vld;
        logic [1:0]     ack;
        logic [1:0]     fl;
        logic [PB-1:0]  d0;
        logic [PB-1:0]  d1;
        logic [1:0]     e_vld;
        logic [1:0]     e_ack;
        logic [CW-1:0]  e_occ0;
        logic [CW-1:0]  e_occ1;
        logic [PB-1:0]  e_head0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [PB-1:0] mq [NCH][$];

    always #5 clk = ~clk;

    leaf_stream_buffer_bank_if #(.NUM_CH(NCH), .PAYLOAD_BITS(PB), .DEPTH_BITS(DB)) bus ();

`ifdef LEAF_STREAM_BUF_STATS_EN
    logic [NCH*16-1:0] stall_cnt;
    logic [NCH*CW-1:0] high_water;
`endif

    leaf_stream_buffer_bank #(.NUM_CH(NCH), .PAYLOAD_BITS(PB), .DEPTH_BITS(DB)) dut (
        .clk_user   (clk),
        .reset      (rst_n),
`ifdef LEAF_STREAM_BUF_STATS_EN
        .stall_cnt  (stall_cnt),
        .high_water (high_water),
`endif
        .bus        (bus)
    );

    task automatic chk(input string nm, input int ch, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s ch%0d at %0t: got %h expected %h", nm, ch, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] a, input logic [1:0] f,
                         input logic [PB-1:0] d0, input logic [PB-1:0] d1);
        rst_n        = r;
        bus.din_vld  = v;
        bus.dout_ack = a;
        bus.flush    = f;
        bus.din_user = {d1, d0};
    endtask

    function automatic logic [PB-1:0] head(input int c);
        return bus.dout_user[c*PB +: PB];
    endfunction

    function automatic logic [CW-1:0] occ(input int c);
        return bus.occupancy[c*CW +: CW];
    endfunction

    // Reference: one queue per channel, advanced by the handshake rules, then compared after the edge
    task automatic cycle();
        for (int c = 0; c < NCH; c++) begin
            logic [PB-1:0] w;
            bit pu;
            bit po;
            w  = bus.din_user[c*PB +: PB];
            pu = bus.din_vld[c] && (mq[c].size() < DEPTH);
            po = bus.dout_ack[c] && (mq[c].size() > 0);
            if (!rst_n || bus.flush[c]) mq[c].delete();
            else begin
                if (po) void'(mq[c].pop_front());
                if (pu) mq[c].push_back(w);
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            chk("din_ack", c, 64'(bus.din_ack[c]), 64'(mq[c].size() < DEPTH));
            chk("dout_vld", c, 64'(bus.dout_vld[c]), 64'(mq[c].size() != 0));
            chk("occupancy", c, 64'(occ(c)), 64'(mq[c].size()));
            if (mq[c].size() != 0) chk("dout_user", c, 64'(head(c)), 64'(mq[c][0]));
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] a, input logic [1:0] f,
                                input logic [PB-1:0] d0, input logic [PB-1:0] d1, input logic [1:0] ev,
                                input logic [1:0] ea, input logic [CW-1:0] o0, input logic [CW-1:0] o1,
                                input logic [PB-1:0] h0);
        vec_t t;
        t.rst_n = r;  t.vld = v;  t.ack = a;  t.fl = f;  t.d0 = d0;  t.d1 = d1;
        t.e_vld = ev; t.e_ack = ea; t.e_occ0 = o0; t.e_occ1 = o1; t.e_head0 = h0;
        return t;
    endfunction

    initial begin
        vec_t tv[12];
        int   ack_pct;
        int   vld_pct;

        tv[0]  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0, 0);
        tv[1]  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0, 0);
        tv[2]  = mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0, 0);
        tv[3]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0, 0);
        tv[4]  = mk(1, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 0, 2'b01, 2'b11, 1, 0, 32'hDEADBEEF);
        tv[5]  = mk(1, 2'b01, 2'b00, 2'b00, 32'h11111111, 0, 2'b01, 2'b11, 2, 0, 32'hDEADBEEF);
        tv[6]  = mk(1, 2'b10, 2'b01, 2'b00, 0, 32'hAAAA0001, 2'b11, 2'b11, 1, 1, 32'h11111111);
        tv[7]  = mk(1, 2'b01, 2'b01, 2'b00, 32'h22222222, 0, 2'b11, 2'b11, 1, 1, 32'h22222222);
        tv[8]  = mk(1, 2'b01, 2'b00, 2'b01, 32'h33333333, 0, 2'b10, 2'b11, 0, 1, 0);
        tv[9]  = mk(1, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 0, 0, 0);
        tv[10] = mk(1, 2'b10, 2'b11, 2'b00, 0, 32'h5, 2'b10, 2'b11, 0, 1, 0);
        tv[11] = mk(0, 2'b01, 2'b00, 2'b00, 32'h9, 0, 2'b00, 2'b11, 0, 0, 0);

        drive(0, 2'b00, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].rst_n, tv[i].vld, tv[i].ack, tv[i].fl, tv[i].d0, tv[i].d1);
            cycle();
            chk("tv_dout_vld", i, 64'(bus.dout_vld), 64'(tv[i].e_vld));
            chk("tv_din_ack", i, 64'(bus.din_ack), 64'(tv[i].e_ack));
            chk("tv_occ0", i, 64'(occ(0)), 64'(tv[i].e_occ0));
            chk("tv_occ1", i, 64'(occ(1)), 64'(tv[i].e_occ1));
            if (tv[i].e_vld[0]) chk("tv_head0", i, 64'(head(0)), 64'(tv[i].e_head0));
        end

        // Fill ch1 to full, overflow attempt, drain in order
        drive(0, 2'b00, 2'b00, 2'b00, 0, 0); cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'b10, 2'b00, 2'b00, 0, PB'(i)); cycle();
        end
        chk("full_ack", 1, 64'(bus.din_ack[1]), 64'(0));
        drive(1, 2'b10, 2'b00, 2'b00, 0, 32'd99); cycle();
        chk("full_occ", 1, 64'(occ(1)), 64'(16));
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 1, 64'(head(1)), 64'(i));
            drive(1, 2'b00, 2'b10, 2'b00, 0, 0); cycle();
        end
        chk("drain_empty", 1, 64'(bus.dout_vld[1]), 64'(0));

        // Steady push+pop at count 8 across several pointer wraps
        drive(0, 2'b00, 2'b00, 2'b00, 0, 0); cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'b01, 2'b00, 2'b00, PB'(i), 0); cycle();
        end
        for (int k = 0; k < 40; k++) begin
            chk("stream_head", 0, 64'(head(0)), 64'(k));
            drive(1, 2'b01, 2'b01, 2'b00, PB'(8 + k), 0); cycle();
            chk("stream_occ", 0, 64'(occ(0)), 64'(8));
        end

        // Flush ch0 only, then reset mid-drain of ch1
        drive(0, 2'b00, 2'b00, 2'b00, 0, 0); cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, {1'(i < 3), 1'b1}, 2'b00, 2'b00, PB'(100 + i), PB'(200 + i)); cycle();
        end
        drive(1, 2'b00, 2'b00, 2'b01, 0, 0);
        chk("preflush_vld", 0, 64'(bus.dout_vld[0]), 64'(1));
        cycle();
        chk("flush_occ0", 0, 64'(occ(0)), 64'(0));
        chk("flush_vld0", 0, 64'(bus.dout_vld[0]), 64'(0));
        chk("flush_occ1", 1, 64'(occ(1)), 64'(3));
        for (int i = 0; i < 2; i++) begin
            chk("ch1_after_flush", 1, 64'(head(1)), 64'(200 + i));
            drive(1, 2'b00, 2'b10, 2'b00, 0, 0); cycle();
        end
        drive(0, 2'b00, 2'b10, 2'b00, 0, 0); cycle();
        chk("reset_vld", 0, 64'(bus.dout_vld), 64'(0));
        chk("reset_occ1", 1, 64'(occ(1)), 64'(0));
        drive(1, 2'b10, 2'b00, 2'b00, 0, 32'd77); cycle();
        chk("post_reset_head", 1, 64'(head(1)), 64'(77));

        // Randomized traffic with varying pressure
        ack_pct = 50;
        vld_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] v;
            logic [1:0] a;
            logic [1:0] f;
            if (n % 250 == 0) begin
                ack_pct = int'($urandom_range(95, 5));
                vld_pct = int'($urandom_range(95, 5));
            end
            for (int c = 0; c < NCH; c++) begin
                v[c] = ($urandom_range(99, 0) < vld_pct);
                a[c] = ($urandom_range(99, 0) < ack_pct);
                f[c] = ($urandom_range(63, 0) == 0);
            end
            drive(($urandom_range(299, 0) != 0), v, a, f, $urandom, $urandom);
            cycle();
        end

`ifdef LEAF_STREAM_BUF_STATS_EN
        drive(0, 2'b00, 2'b00, 2'b00, 0, 0); cycle();
        chk("stall_reset", 0, 64'(stall_cnt), 64'(0));
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'b01, 2'b00, 2'b00, PB'(i), 0); cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'b01, 2'b00, 2'b00, 32'hBAD, 0); cycle();
        end
        chk("stall_cnt", 0, 64'(stall_cnt[15:0]), 64'(10));
        chk("high_water", 0, 64'(high_water[CW-1:0]), 64'(16));
        chk("stall_ch1", 1, 64'(stall_cnt[31:16]), 64'(0));
        drive(1, 2'b00, 2'b00, 2'b01, 0, 0); cycle();
        chk("stall_flush", 0, 64'(stall_cnt[15:0]), 64'(0));
        chk("hw_flush", 0, 64'(high_water[CW-1:0]), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/leaf_stream_buffer_bank.md
Name: leaf_stream_buffer_bank

Overview:
- Parametrised bank of NUM_CH independent elastic FIFOs.
- Sits between an HLS user kernel's ap_vld/ap_ack stream ports and the leaf interface's user-side ports, all inside the clk_user domain.
- Generalises the fixed one-in/two-out leaf wiring to any channel count, payload width and buffer depth.
- Adds decoupling buffering, per-channel flush and occupancy reporting, none of which a direct wire-through provides.

Parameters:
- NUM_CH, 2: number of independent stream channels (1..16).
- PAYLOAD_BITS, 32: data width per channel.
- DEPTH_BITS, 4: log2 of FIFO depth per channel; depth = 2**DEPTH_BITS (2..1024).

Ports:
- clk_user  in  1  user clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- din_user  in  NUM_CH*PAYLOAD_BITS  write data; channel c occupies bits [c*PAYLOAD_BITS +: PAYLOAD_BITS].
- din_vld  in  NUM_CH  per-channel write valid (producer ap_vld).
- din_ack  out  NUM_CH  per-channel write accept (to producer ap_ack).
- dout_user  out  NUM_CH*PAYLOAD_BITS  read data; same packing as din_user.
- dout_vld  out  NUM_CH  per-channel read valid (to consumer ap_vld).
- dout_ack  in  NUM_CH  per-channel read accept (consumer ap_ack).
- flush  in  NUM_CH  per-channel synchronous clear request.
- occupancy  out  NUM_CH*(DEPTH_BITS+1)  per-channel entry count; channel c occupies bits [c*(DEPTH_BITS+1) +: DEPTH_BITS+1].

Behaviour:
- Handshake rules:
  - A transfer occurs on a cycle where vld and ack are both high.
  - din_ack[c] = !full[c]; dout_vld[c] = !empty[c].
  - Both are driven from registered state only: no combinational path from any input to din_ack or dout_vld.
  - dout_user[c] shows the head entry whenever dout_vld[c]=1. Its value is don't-care when empty, but must hold stable while dout_vld[c]=1 and dout_ack[c]=0.
- Per-channel state:
  - Write pointer, read pointer, count (DEPTH_BITS+1 bits) and a DEPTH x PAYLOAD_BITS storage array.
  - Pointers wrap modulo depth.
  - Storage may infer LUTRAM/BRAM, but the read data path must present the head combinationally from the registered read pointer, or use a prefetch register with identical external timing.
- Latency: a word written in cycle N is visible at dout with dout_vld=1 in cycle N+1. There is no same-cycle bypass.
- Full/empty boundary conditions:
  - Count = depth: din_ack=0, and din_vld is ignored.
  - Count = 0: dout_vld=0, and dout_ack is ignored.
  - Simultaneous push and pop with 0 < count < depth: both happen and count is unchanged.
  - Push when count = depth-1 with no pop: count becomes depth and din_ack drops the next cycle.
  - Pop at count = 1 with a simultaneous push: dout_vld stays 1 and the new word becomes head.
- Wrap-around: after 2*depth continuous pushes/pops, data order is preserved exactly (FIFO order, no loss, no duplication).
- Flush:
  - flush[c]=1 in cycle N clears the pointers and count of channel c at edge N.
  - Any push or pop on channel c in that cycle is discarded; din_ack and dout_vld still show their pre-flush values during cycle N.
  - Other channels are unaffected.
- Channels are fully independent. No shared arbitration, and no cross-channel stalls.
- Reset (reset=0 at a clock edge):
  - All counts and pointers become 0.
  - dout_vld=0, din_ack=all ones from the next cycle, occupancy=0.
  - Storage contents are not reset.
- Reset asserted mid-transfer discards all buffered data; the first post-reset word on each channel is the first accepted after reset deasserts.
- occupancy[c] equals the registered count, updated one cycle after each accepted push or pop.

Optional Feature:
- Macro: LEAF_STREAM_BUF_STATS_EN.
- When defined, two extra output ports are added:
  - stall_cnt  out  NUM_CH*16: per-channel saturating count of cycles with din_vld=1 and din_ack=0.
  - high_water  out  NUM_CH*(DEPTH_BITS+1): per-channel maximum occupancy seen.
- Stats behaviour:
  - Both are cleared by reset and by flush[c] for their channel.
  - stall_cnt saturates at 16'hFFFF.
  - high_water updates in the same cycle as occupancy.
- When undefined, these ports and their logic do not exist, and the module interface is exactly as listed above.

Test Plan:
- Reset, NUM_CH=2, DEPTH_BITS=4: hold reset=0 for 3 cycles -> dout_vld=2'b00, din_ack=2'b11, occupancy=0.
- Single word: push 32'hDEADBEEF on ch0 in cycle 5 with dout_ack=0 -> dout_vld[0]=1 in cycle 6 with data DEADBEEF, occupancy[0]=1; ch1 stays empty.
- Fill to full: push 16 words 0..15 on ch1 with dout_ack[1]=0 -> din_ack[1]=0 after the 16th; a 17th din_vld is ignored; draining yields exactly 0..15 in order.
- Concurrent push and pop: at count=8, hold din_vld=dout_ack=1 for 40 cycles with incrementing data -> count stays 8, output sequence is contiguous across pointer wrap, nothing lost.
- Flush vs. reset: ch0 holds 5 words and ch1 holds 3; pulse flush=2'b01 -> ch0 occupancy=0 and dout_vld[0]=0 next cycle, ch1 still outputs its 3 words; then assert reset=0 mid-drain -> all channels empty.
- With LEAF_STREAM_BUF_STATS_EN defined: hold ch0 full with din_vld=1 for 10 cycles -> stall_cnt[ch0]=10, high_water[ch0]=16; flush ch0 -> both read 0.
